// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the instruction ROM: IDLE -> RUN -> HALTED.
// Chooses the next PC each RUN cycle and counts the cycles spent in RUN.
module fetch_ctrl #(
    parameter int             PC_W       = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            br_abs,
    input  logic            br_rel,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] PC,
    output logic            fetch_valid,
    output logic            done,
    output logic [15:0]     cycle_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]      state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     cnt_q;
    logic [15:0]     cnt_next;

    // Next PC while running; the halting cycle and stalls keep the current address.
    always_comb begin
        pc_next = pc_q;
        if (halt_req || stall) begin
            pc_next = pc_q;
        end else if (br_abs) begin
            pc_next = target;
        end else if (br_rel) begin
            pc_next = pc_q + offset;
        end else begin
            pc_next = pc_q + 1'b1;
        end
    end

    always_comb begin
        cnt_next = cnt_q;
        if (cnt_q != 16'hFFFF) begin
            cnt_next = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state <= IDLE;
            pc_q  <= START_ADDR;
            cnt_q <= 16'd0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state <= RUN;
                        pc_q  <= START_ADDR;
                        cnt_q <= 16'd0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_next;
                    pc_q  <= pc_next;
                    if (halt_req) begin
                        state <= HALTED;
                    end
                end
                default: begin
                    state <= IDLE;
                    pc_q  <= START_ADDR;
                    cnt_q <= 16'd0;
                end
            endcase
        end
    end

    assign PC          = pc_q;
    assign cycle_cnt   = cnt_q;
    assign fetch_valid = (state == RUN);
    assign done        = (state == HALTED);

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, 16, program counter width; matches the 16-bit instruction-ROM address.
REQ-002 SHALL have parameter START_ADDR, 16'h0000, address loaded into PC on reset and on every start.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 SHALL have port start  input  1  begin program execution from START_ADDR; honoured only in IDLE or HALTED.
REQ-006 SHALL have port stall  input  1  hold PC for this cycle (datapath busy).
REQ-007 SHALL have port halt_req  input  1  halt instruction decoded (inst == 9'b111_111_111).
REQ-008 SHALL have port br_abs  input  1  absolute branch taken this cycle.
REQ-009 SHALL have port br_rel  input  1  relative branch taken this cycle.
REQ-010 SHALL have port target  input  PC_W  absolute branch destination.
REQ-011 SHALL have port offset  input  PC_W  signed two's-complement relative branch offset.
REQ-012 SHALL have port PC  output  PC_W  instruction-ROM address; the ROM reads it combinationally.
REQ-013 SHALL have port fetch_valid  output  1  the instruction at PC is to be executed this cycle.
REQ-014 SHALL have port done  output  1  program halted.
REQ-015 SHALL have port cycle_cnt  output  16  number of RUN cycles since the last start.

Function
REQ-016 SHALL implement the states IDLE, RUN and HALTED; all outputs SHALL be registered or decoded from state only.
REQ-017 IDLE: PC = START_ADDR, fetch_valid = 0, done = 0; start = 1 -> RUN on the next edge.
REQ-018 fetch_valid SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in HALTED.
REQ-019 In RUN the next PC SHALL be selected by fixed priority: halt_req > stall > br_abs > br_rel > increment.
REQ-020 halt_req in RUN: PC held, next state HALTED; stall, br_abs and br_rel ignored that cycle.
REQ-021 stall (no halt_req): PC held, state stays RUN, branches that cycle discarded (the requester re-asserts them).
REQ-022 br_abs: PC <= target; br_abs and br_rel asserted together: br_abs wins.
REQ-023 br_rel: PC <= PC + offset modulo 2^PC_W (16'h0002 + 16'hFFFD = 16'hFFFF).
REQ-024 Increment: PC <= PC + 1; 16'hFFFF wraps to 16'h0000 with no error flag.
REQ-025 start, stall, halt_req, br_abs and br_rel SHALL be ignored outside RUN, except start as per REQ-017/026.
REQ-026 HALTED: PC held at the halt address; start = 1 -> RUN with PC = START_ADDR and cycle_cnt = 0 on the same edge.
REQ-027 start while in RUN SHALL be ignored (no restart).
REQ-028 cycle_cnt SHALL increment by 1 on every edge spent in RUN, stalled cycles and the halting cycle included; saturates at 16'hFFFF; held in IDLE/HALTED.
REQ-029 Latency: first fetch_valid = 1 one cycle after start is sampled; done = 1 one cycle after halt_req is sampled.

Reset
REQ-030 reset_n = 0 at a rising edge SHALL force state IDLE, PC = START_ADDR, fetch_valid = 0, done = 0, cycle_cnt = 0, regardless of the current state or any other input.
REQ-031 Reset mid-RUN SHALL discard any pending branch/stall; start sampled with reset_n = 0 SHALL be ignored.
REQ-032 Between edges, reset_n SHALL have no effect on the outputs (synchronous reset only).

Verification
REQ-033 Reset, then start pulse, no other inputs for 4 cycles -> PC 0,1,2,3; fetch_valid = 1 from the cycle after start; cycle_cnt = 4.
REQ-034 In RUN at PC = 5, br_abs = 1, target = 16'h0008 and br_rel = 1 together -> PC = 8 next cycle; then br_rel with offset 16'hFFFD -> PC = 5.
REQ-035 At PC = 7, stall = 1 for 3 cycles with br_abs asserted -> PC stays 7 for 3 cycles, then 8; cycle_cnt advances by 4.
REQ-036 At PC = 9, halt_req = 1 -> done = 1 and fetch_valid = 0 next cycle, PC = 9 held; start -> PC = 0, cycle_cnt = 0, fetch_valid = 1.
REQ-037 Force PC = 16'hFFFF in RUN with no branch -> PC = 16'h0000 next cycle, state remains RUN.
REQ-038 reset_n = 0 for one edge while in RUN at PC = 12 with br_abs = 1 -> PC = 0, IDLE, done = 0, cycle_cnt = 0; no fetch until the next start.
